// File: rtl/mips_isa_pkg.sv
// Shared MIPS ISA constants: opcodes, loader instruction-class codes and loader FSM states.
package mips_isa_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0c;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    localparam logic [5:0] FUNCT_JR = 6'h08;

    localparam logic [3:0] CLS_ADDI = 4'h1;
    localparam logic [3:0] CLS_ORI  = 4'h2;
    localparam logic [3:0] CLS_ANDI = 4'h3;
    localparam logic [3:0] CLS_LUI  = 4'h4;
    localparam logic [3:0] CLS_SW   = 4'h5;
    localparam logic [3:0] CLS_LW   = 4'h6;
    localparam logic [3:0] CLS_BEQ  = 4'h7;
    localparam logic [3:0] CLS_BNE  = 4'h8;
    localparam logic [3:0] CLS_J    = 4'h9;
    localparam logic [3:0] CLS_JAL  = 4'hA;
    localparam logic [3:0] CLS_JR   = 4'hB;
    localparam logic [3:0] CLS_R    = 4'hF;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_DRAIN = 3'd2,
        ST_DONE  = 3'd3,
        ST_TRAP  = 3'd4
    } loaderState_t;

endpackage

// File: rtl/mips_instr_enc.sv
// Combinational MIPS word packer: instruction class plus fields -> 32-bit word and illegal flag.
module mips_instr_enc
    import mips_isa_pkg::*;
(
    input  logic [3:0]  instrClass,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [4:0]  shamt,
    input  logic [5:0]  funct,
    input  logic [15:0] imm,
    input  logic [25:0] target,
    output logic [31:0] word,
    output logic        illegal
);

    always_comb begin
        word    = 32'h0000_0000;
        illegal = 1'b0;
        case (instrClass)
            CLS_R:    word = {OP_RTYPE, rs, rt, rd, shamt, funct};
            CLS_JR:   word = {OP_RTYPE, rs, 15'd0, FUNCT_JR};
            CLS_LUI:  word = {OP_LUI, 5'd0, rt, imm};
            CLS_ADDI: word = {OP_ADDI, rs, rt, imm};
            CLS_ORI:  word = {OP_ORI, rs, rt, imm};
            CLS_ANDI: word = {OP_ANDI, rs, rt, imm};
            CLS_SW:   word = {OP_SW, rs, rt, imm};
            CLS_LW:   word = {OP_LW, rs, rt, imm};
            CLS_BEQ:  word = {OP_BEQ, rs, rt, imm};
            CLS_BNE:  word = {OP_BNE, rs, rt, imm};
            CLS_J:    word = {OP_J, target};
            CLS_JAL:  word = {OP_JAL, target};
            // Unknown classes become a nop so a careless program cannot emit garbage.
            default:  illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/mips_instr_encoder_loader.sv
// Encodes instruction fields, buffers words in a small FIFO and writes them to sequential addresses.
// Optional macro ENC_ILLEGAL_TRAP_EN: an unknown class halts loading in a TRAP state instead of writing a nop.
module mips_instr_encoder_loader
    import mips_isa_pkg::*;
#(
    parameter int                ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = 'h0040_0000,
    parameter int                FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_last,
    input  logic [3:0]        in_class,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_shamt,
    input  logic [5:0]        in_funct,
    input  logic [15:0]       in_imm,
    input  logic [25:0]       in_target,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ready,
    output logic              busy,
    output logic              done,
    output logic [15:0]       count,
    output logic              illegal
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    loaderState_t stateReg, stateNext;

    logic [31:0]      fifoMem [FIFO_DEPTH];
    logic [PTR_W:0]   wrPtrReg, rdPtrReg;
    logic [ADDR_W-1:0] memAddrReg;
    logic [15:0]      countReg;
    logic             illegalReg;

    logic [31:0] encWord;
    logic        encIllegal;
    logic        fifoEmpty, fifoFull;
    logic        accept, doPush, doPop, startHonoured;

    mips_instr_enc encoder (
        .instrClass (in_class),
        .rs         (in_rs),
        .rt         (in_rt),
        .rd         (in_rd),
        .shamt      (in_shamt),
        .funct      (in_funct),
        .imm        (in_imm),
        .target     (in_target),
        .word       (encWord),
        .illegal    (encIllegal)
    );

    // Extra pointer MSB distinguishes full from empty when the index bits match.
    assign fifoEmpty = (wrPtrReg == rdPtrReg);
    assign fifoFull  = (wrPtrReg[PTR_W] != rdPtrReg[PTR_W]) &&
                       (wrPtrReg[PTR_W-1:0] == rdPtrReg[PTR_W-1:0]);

    assign in_ready      = (stateReg == ST_LOAD) && !fifoFull;
    assign accept        = in_valid && in_ready;
    assign doPop         = mem_we && mem_ready;
    assign startHonoured = start && ((stateReg == ST_IDLE) || (stateReg == ST_DONE));

`ifdef ENC_ILLEGAL_TRAP_EN
    assign doPush = accept && !encIllegal;
`else
    assign doPush = accept;
`endif

    always_ff @(posedge clk) begin
        if (doPush) begin
            fifoMem[wrPtrReg[PTR_W-1:0]] <= encWord;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stateReg   <= ST_IDLE;
            wrPtrReg   <= '0;
            rdPtrReg   <= '0;
            memAddrReg <= BASE_ADDR;
            countReg   <= 16'd0;
            illegalReg <= 1'b0;
        end else begin
            stateReg <= stateNext;
            if (doPush) begin
                wrPtrReg <= wrPtrReg + (PTR_W+1)'(1);
            end
            if (startHonoured) begin
                memAddrReg <= BASE_ADDR;
                countReg   <= 16'd0;
                illegalReg <= 1'b0;
            end else begin
                if (doPop) begin
                    rdPtrReg   <= rdPtrReg + (PTR_W+1)'(1);
                    memAddrReg <= memAddrReg + ADDR_W'(4);
                    if (countReg != 16'hFFFF) begin
                        countReg <= countReg + 16'd1;
                    end
                end
                if (accept && encIllegal) begin
                    illegalReg <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        stateNext = stateReg;
        case (stateReg)
            ST_IDLE:  if (start) stateNext = ST_LOAD;
            ST_LOAD: begin
                if (accept) begin
`ifdef ENC_ILLEGAL_TRAP_EN
                    if (encIllegal)   stateNext = ST_TRAP;
                    else if (in_last) stateNext = ST_DRAIN;
`else
                    if (in_last) stateNext = ST_DRAIN;
`endif
                end
            end
            ST_DRAIN: if (fifoEmpty) stateNext = ST_DONE;
            ST_DONE:  if (start) stateNext = ST_LOAD;
            ST_TRAP:  stateNext = ST_TRAP;
            default:  stateNext = ST_IDLE;
        endcase
    end

    assign mem_we    = !fifoEmpty;
    assign mem_addr  = memAddrReg;
    assign mem_wdata = fifoEmpty ? 32'h0000_0000 : fifoMem[rdPtrReg[PTR_W-1:0]];
    assign busy      = (stateReg == ST_LOAD) || (stateReg == ST_DRAIN);
    assign done      = (stateReg == ST_DONE);
    assign count     = countReg;
    assign illegal   = illegalReg;

endmodule

// File: tb/tb_mips_instr_encoder_loader.sv
// Directed testbench for mips_instr_encoder_loader; captures every accepted memory write.
module tb_mips_instr_encoder_loader;

    localparam logic [31:0] BASE = 32'h0040_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_last = 1'b0;
    logic [3:0]  in_class = 4'd0;
    logic [4:0]  in_rs = 5'd0, in_rt = 5'd0, in_rd = 5'd0, in_shamt = 5'd0;
    logic [5:0]  in_funct = 6'd0;
    logic [15:0] in_imm = 16'd0;
    logic [25:0] in_target = 26'd0;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready = 1'b0;
    logic        busy, done, illegal;
    logic [15:0] count;

    int total = 0;
    int bad = 0;

    logic [31:0] capAddr [32];
    logic [31:0] capData [32];
    int          capN = 0;
    int          capStart;

    mips_instr_encoder_loader dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_last   (in_last),
        .in_class  (in_class),
        .in_rs     (in_rs),
        .in_rt     (in_rt),
        .in_rd     (in_rd),
        .in_shamt  (in_shamt),
        .in_funct  (in_funct),
        .in_imm    (in_imm),
        .in_target (in_target),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ready (mem_ready),
        .busy      (busy),
        .done      (done),
        .count     (count),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!reset && mem_we && mem_ready) begin
            if (capN < 32) begin
                capAddr[capN] <= mem_addr;
                capData[capN] <= mem_wdata;
            end
            capN <= capN + 1;
            $display("write addr=%08h data=%08h", mem_addr, mem_wdata);
        end
    end

    task automatic doReset();
        reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0; mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic doStart();
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        capStart = capN;
    endtask

    // Offers one instruction and returns #1 after the edge that accepted it.
    task automatic sendInstr(input logic [3:0] cls, input logic [4:0] rs, input logic [4:0] rt,
                             input logic [4:0] rd, input logic [4:0] sh, input logic [5:0] fn,
                             input logic [15:0] imm, input logic [25:0] tgt, input logic last);
        logic accepted;
        accepted = 1'b0;
        in_class = cls; in_rs = rs; in_rt = rt; in_rd = rd; in_shamt = sh;
        in_funct = fn; in_imm = imm; in_target = tgt; in_last = last; in_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (in_ready) begin
                accepted = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        total++;
        if (!accepted) begin
            bad++;
            $display("FAIL accept_timeout: in_ready=%0b required=1 class=%h", in_ready, cls);
        end else begin
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic waitDone();
        for (int i = 0; i < 200; i++) begin
            if (done) break;
            @(posedge clk); #1;
        end
        total++;
        if (done !== 1'b1) begin
            bad++;
            $display("FAIL done_timeout: done=%0b required=1", done);
        end
    endtask

    task automatic test_reset();
        doReset();
        total++; if (mem_we !== 1'b0)       begin bad++; $display("FAIL rst_we: got=%0b exp=0", mem_we); end
        total++; if (mem_addr !== BASE)     begin bad++; $display("FAIL rst_addr: got=%08h exp=%08h", mem_addr, BASE); end
        total++; if (mem_wdata !== 32'd0)   begin bad++; $display("FAIL rst_wdata: got=%08h exp=0", mem_wdata); end
        total++; if (in_ready !== 1'b0)     begin bad++; $display("FAIL rst_ready: got=%0b exp=0", in_ready); end
        total++; if ({busy, done, illegal} !== 3'b000) begin bad++; $display("FAIL rst_flags: got=%03b exp=000", {busy, done, illegal}); end
        total++; if (count !== 16'd0)       begin bad++; $display("FAIL rst_count: got=%0d exp=0", count); end
        // in_valid while IDLE must not be buffered
        in_class = 4'h1; in_valid = 1'b1; mem_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 in_valid = 1'b0;
        total++; if (mem_we !== 1'b0 || capN != 0) begin bad++; $display("FAIL idle_ignore: we=%0b writes=%0d exp=0", mem_we, capN); end
        $display("test_reset complete");
    endtask

    task automatic test_addi();
        doReset();
        mem_ready = 1'b1;
        doStart();
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL start_busy: got=%0b exp=1", busy); end
        sendInstr(4'h1, 5'd0, 5'd8, 5'd0, 5'd0, 6'd0, 16'd5, 26'd0, 1'b1);
        total++; if (mem_we !== 1'b1 || mem_wdata !== 32'h2008_0005) begin bad++; $display("FAIL addi_latency: we=%0b data=%08h exp 1/20080005", mem_we, mem_wdata); end
        waitDone();
        total++; if (capN - capStart != 1) begin bad++; $display("FAIL addi_nwrites: got=%0d exp=1", capN - capStart); end
        total++; if (capData[capStart] !== 32'h2008_0005 || capAddr[capStart] !== BASE) begin bad++; $display("FAIL addi_write: data=%08h addr=%08h exp 20080005@%08h", capData[capStart], capAddr[capStart], BASE); end
        total++; if (count !== 16'd1) begin bad++; $display("FAIL addi_count: got=%0d exp=1", count); end
        total++; if (mem_addr !== BASE + 32'd4) begin bad++; $display("FAIL addi_nextaddr: got=%08h exp=%08h", mem_addr, BASE + 32'd4); end
        $display("test_addi complete");
    endtask

    task automatic test_r_and_j();
        doReset();
        mem_ready = 1'b1;
        doStart();
        sendInstr(4'hF, 5'd9, 5'd10, 5'd8, 5'd0, 6'h20, 16'd0, 26'd0, 1'b0);
        sendInstr(4'h9, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'h010_0000, 1'b1);
        waitDone();
        total++; if (capData[capStart] !== 32'h012A_4020 || capAddr[capStart] !== BASE) begin bad++; $display("FAIL r_add: data=%08h addr=%08h exp 012a4020@%08h", capData[capStart], capAddr[capStart], BASE); end
        total++; if (capData[capStart+1] !== 32'h0810_0000 || capAddr[capStart+1] !== BASE + 32'd4) begin bad++; $display("FAIL j_word: data=%08h addr=%08h exp 08100000@%08h", capData[capStart+1], capAddr[capStart+1], BASE + 32'd4); end
        total++; if (count !== 16'd2) begin bad++; $display("FAIL rj_count: got=%0d exp=2", count); end
        $display("test_r_and_j complete");
    endtask

    task automatic test_back_to_back();
        logic [31:0] expWords [6];
        expWords[0] = 32'h2001_0011; expWords[1] = 32'h2002_0012; expWords[2] = 32'h2003_0013;
        expWords[3] = 32'h2004_0014; expWords[4] = 32'h2005_0015; expWords[5] = 32'h2006_0016;
        doReset();
        mem_ready = 1'b0;
        doStart();
        for (int i = 1; i <= 4; i++)
            sendInstr(4'h1, 5'd0, 5'(i), 5'd0, 5'd0, 6'd0, 16'(i + 16), 26'd0, 1'b0);
        in_class = 4'h1; in_rt = 5'd5; in_imm = 16'h0015; in_valid = 1'b1;
        for (int c = 0; c < 6; c++) begin
            total++;
            if (in_ready !== 1'b0 || mem_we !== 1'b1 || mem_addr !== BASE || mem_wdata !== 32'h2001_0011) begin
                bad++;
                $display("FAIL stall_hold: cyc=%0d ready=%0b we=%0b addr=%08h data=%08h exp 0/1/%08h/20010011", c, in_ready, mem_we, mem_addr, mem_wdata, BASE);
            end
            @(posedge clk); #1;
        end
        mem_ready = 1'b1;
        sendInstr(4'h1, 5'd0, 5'd5, 5'd0, 5'd0, 6'd0, 16'h0015, 26'd0, 1'b0);
        sendInstr(4'h1, 5'd0, 5'd6, 5'd0, 5'd0, 6'd0, 16'h0016, 26'd0, 1'b1);
        waitDone();
        total++; if (capN - capStart != 6) begin bad++; $display("FAIL b2b_nwrites: got=%0d exp=6", capN - capStart); end
        for (int i = 0; i < 6; i++) begin
            total++;
            if (capData[capStart+i] !== expWords[i] || capAddr[capStart+i] !== BASE + 32'(4*i)) begin
                bad++;
                $display("FAIL b2b_word%0d: data=%08h addr=%08h exp %08h@%08h", i, capData[capStart+i], capAddr[capStart+i], expWords[i], BASE + 32'(4*i));
            end
        end
        total++; if (count !== 16'd6) begin bad++; $display("FAIL b2b_count: got=%0d exp=6", count); end
        $display("test_back_to_back complete");
    endtask

    task automatic test_jr_lui();
        doReset();
        mem_ready = 1'b1;
        doStart();
        sendInstr(4'hB, 5'd31, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'd0, 1'b0);
        sendInstr(4'h4, 5'd0, 5'd1, 5'd0, 5'd0, 6'd0, 16'h1001, 26'd0, 1'b1);
        waitDone();
        total++; if (capData[capStart] !== 32'h03E0_0008) begin bad++; $display("FAIL jr_word: got=%08h exp=03e00008", capData[capStart]); end
        total++; if (capData[capStart+1] !== 32'h3C01_1001) begin bad++; $display("FAIL lui_word: got=%08h exp=3c011001", capData[capStart+1]); end
        $display("test_jr_lui complete");
    endtask

    task automatic test_illegal();
        doReset();
        mem_ready = 1'b1;
        doStart();
        sendInstr(4'h0, 5'd3, 5'd4, 5'd5, 5'd0, 6'd0, 16'hFFFF, 26'd0, 1'b1);
`ifdef ENC_ILLEGAL_TRAP_EN
        repeat (5) @(posedge clk);
        #1;
        total++; if (illegal !== 1'b1) begin bad++; $display("FAIL trap_illegal: got=%0b exp=1", illegal); end
        total++; if (in_ready !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL trap_state: ready=%0b done=%0b exp 0/0", in_ready, done); end
        total++; if (capN != capStart || mem_we !== 1'b0) begin bad++; $display("FAIL trap_nowrite: writes=%0d we=%0b exp 0/0", capN - capStart, mem_we); end
`else
        waitDone();
        total++; if (illegal !== 1'b1) begin bad++; $display("FAIL nop_illegal: got=%0b exp=1", illegal); end
        total++; if (capN - capStart != 1 || capData[capStart] !== 32'h0000_0000) begin bad++; $display("FAIL nop_word: writes=%0d data=%08h exp 1/00000000", capN - capStart, capData[capStart]); end
        doStart();
        total++; if (illegal !== 1'b0) begin bad++; $display("FAIL illegal_clear: got=%0b exp=0", illegal); end
`endif
        $display("test_illegal complete");
    endtask

    task automatic test_reset_drain();
        doReset();
        mem_ready = 1'b0;
        doStart();
        sendInstr(4'h1, 5'd0, 5'd1, 5'd0, 5'd0, 6'd0, 16'd1, 26'd0, 1'b0);
        sendInstr(4'h1, 5'd0, 5'd2, 5'd0, 5'd0, 6'd0, 16'd2, 26'd0, 1'b0);
        sendInstr(4'h1, 5'd0, 5'd3, 5'd0, 5'd0, 6'd0, 16'd3, 26'd0, 1'b1);
        total++; if (busy !== 1'b1 || mem_we !== 1'b1) begin bad++; $display("FAIL drain_pre: busy=%0b we=%0b exp 1/1", busy, mem_we); end
        reset = 1'b1;
        #1;
        total++; if (mem_we !== 1'b0 || mem_addr !== BASE || count !== 16'd0) begin bad++; $display("FAIL async_reset: we=%0b addr=%08h count=%0d exp 0/%08h/0", mem_we, mem_addr, count, BASE); end
        @(posedge clk); #1 reset = 1'b0;
        mem_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        total++; if (capN != capStart || mem_we !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL post_reset: writes=%0d we=%0b busy=%0b exp 0/0/0", capN - capStart, mem_we, busy); end
        $display("test_reset_drain complete");
    endtask

    initial begin
        test_reset();
        test_addi();
        test_r_and_j();
        test_back_to_back();
        test_jr_lui();
        test_illegal();
        test_reset_drain();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
